// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the fetch state encoding.
// FETCH_MISALIGN_TRAP_EN adds the HALT state used by the misaligned-target trap.
package riscv_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  // ADDI x0,x0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_REQ   = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
`else
    S_ISSUE = 2'd2
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus: instruction memory port, instruction issue port and the
// decoder/ALU results fed back for next-PC selection.
//
// Handshakes: a transfer happens on a rising edge where both sides are high
// (imem_req & imem_ready, instr_valid & instr_ready). The initiator holds its
// request and payload stable until that edge and never drops it early; the
// responder may hold its ready low for any number of cycles.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        jump;
  logic        jalr;
  logic [2:0]  funct3;
  logic        zero;
  logic [31:0] imm;
  logic [31:0] alu_result;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
    input  imem_ready, imem_rdata, instr_ready,
    input  branch, jump, jalr, funct3, zero, imm, alu_result
  );

  // Memory / decoder / datapath side
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc, pc_plus4,
    output imem_ready, imem_rdata, instr_ready,
    output branch, jump, jalr, funct3, zero, imm, alu_result
  );
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: jalr > jump > taken branch > pc + 4.
module next_pc_sel
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic [31:0] next_pc,
  output logic        taken
);

  // Branch condition and prioritised target mux; all adds wrap modulo 2^32.
  always_comb begin
    taken = 1'b0;
    if (branch) begin
      if (funct3 == F3_BEQ)      taken = zero;
      else if (funct3 == F3_BNE) taken = ~zero;
      else                       taken = 1'b0;
    end

    next_pc = pc + 32'd4;
    if (jalr)                next_pc = alu_result & ~32'h1;
    else if (jump || taken)  next_pc = pc + imm;
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch and program counter. Fetches one word per REQ/ISSUE pass
// and picks the next PC when the datapath accepts the held instruction.
// Optional: FETCH_MISALIGN_TRAP_EN halts on a target with pc[1:0] != 0.
module fetch_pc_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_pc_unit_if.master      bus,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                 misalign_fault,
`endif
  output fetch_state_t         state_dbg
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic         instr_valid_q;
  logic         imem_req_q;
  logic [31:0]  next_pc;
  logic         taken;
  logic         accept;

  assign accept = instr_valid_q & bus.instr_ready;

  next_pc_sel u_next_pc_sel (
    .pc         (pc_q),
    .branch     (bus.branch),
    .jump       (bus.jump),
    .jalr       (bus.jalr),
    .funct3     (bus.funct3),
    .zero       (bus.zero),
    .imm        (bus.imm),
    .alu_result (bus.alu_result),
    .next_pc    (next_pc),
    .taken      (taken)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q;
  assign misalign_fault = fault_q;
`endif

  // Fetch FSM; every output is a register so the handshakes are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_RESET;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_RESET: begin
          imem_req_q <= 1'b1;
          state_q    <= S_REQ;
        end
        S_REQ: begin
          if (bus.imem_ready) begin
            instr_q       <= bus.imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (accept) begin
            pc_q          <= next_pc;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              fault_q    <= 1'b1;
              imem_req_q <= 1'b0;
              state_q    <= S_HALT;
            end else begin
              imem_req_q <= 1'b1;
              state_q    <= S_REQ;
            end
`else
            imem_req_q    <= 1'b1;
            state_q       <= S_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: begin
          // Only rst leaves HALT.
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
`endif
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: memory/datapath driver tasks, a fetch-address
// scoreboard and a summary line. FETCH_MISALIGN_TRAP_EN adds the trap test.
module tb_fetch_pc_unit;
  import riscv_pkg::*;

  logic         clk;
  logic         rst;
  fetch_state_t state_dbg;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         misalign_fault;
`endif

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.master),
`ifdef FETCH_MISALIGN_TRAP_EN
    .misalign_fault (misalign_fault),
`endif
    .state_dbg      (state_dbg)
  );

  localparam logic [31:0] NOP = 32'h0000_0013;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.imem_ready  = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    bus.branch      = 1'b0;
    bus.jump        = 1'b0;
    bus.jalr        = 1'b0;
    bus.funct3      = 3'b0;
    bus.zero        = 1'b0;
    bus.imm         = 32'h0;
    bus.alu_result  = 32'h0;
  endtask

  // Scoreboard: every completed fetch handshake pops the expected address.
  always @(negedge clk) begin
    if (!rst && bus.imem_req === 1'b1 && bus.imem_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL fetch_addr: fetch at %h, no fetch expected", bus.imem_addr);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (bus.imem_addr !== e) begin
          n_fail++;
          $display("FAIL fetch_addr: got %h expected %h", bus.imem_addr, e);
        end
      end
    end
  end

  // Driver: serve one fetch after fetch_delay cycles of imem_ready low.
  task automatic fetch_one(input int fetch_delay, input logic [31:0] exp_addr,
                           output logic [31:0] word);
    int t;
    t = 0;
    while (bus.imem_req !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    n_checks++;
    if (t == 20) begin
      n_fail++;
      $display("FAIL fetch_wait: imem_req=%b after 20 cycles, expected 1", bus.imem_req);
    end
    for (int i = 0; i < fetch_delay; i++) begin
      step();
      n_checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== exp_addr || bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_stall: req=%b addr=%h valid=%b expected 1 %h 0",
                 bus.imem_req, bus.imem_addr, bus.instr_valid, exp_addr);
      end
    end
    word            = $urandom;
    bus.imem_rdata  = word;
    bus.imem_ready  = 1'b1;
    step();
    bus.imem_ready  = 1'b0;
    bus.imem_rdata  = $urandom;
    n_checks++;
    if (bus.instr !== word || bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_load: instr=%h valid=%b req=%b expected %h 1 0",
               bus.instr, bus.instr_valid, bus.imem_req, word);
    end
  endtask

  // Driver: accept the held instruction after accept_delay stall cycles.
  task automatic accept_one(input int accept_delay, input logic [31:0] exp_pc,
                            input logic [31:0] exp_instr,
                            input logic br, input logic jp, input logic jr,
                            input logic [2:0] f3, input logic z,
                            input logic [31:0] imm, input logic [31:0] alu,
                            input logic [31:0] exp_next);
    exp_q.push_back(exp_next);
    n_checks++;
    if (bus.pc !== exp_pc || bus.pc_plus4 !== exp_pc + 32'd4) begin
      n_fail++;
      $display("FAIL issue_pc: pc=%h pc_plus4=%h expected %h %h",
               bus.pc, bus.pc_plus4, exp_pc, exp_pc + 32'd4);
    end
    for (int i = 0; i < accept_delay; i++) begin
      // Noise on the feedback inputs must be ignored until accept.
      bus.branch     = 1'($urandom);
      bus.jump       = 1'($urandom);
      bus.jalr       = 1'($urandom);
      bus.zero       = 1'($urandom);
      bus.imm        = $urandom;
      bus.alu_result = $urandom;
      step();
      n_checks++;
      if (bus.instr !== exp_instr || bus.pc !== exp_pc || bus.instr_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL issue_stall: instr=%h pc=%h valid=%b expected %h %h 1",
                 bus.instr, bus.pc, bus.instr_valid, exp_instr, exp_pc);
      end
    end
    bus.branch      = br;
    bus.jump        = jp;
    bus.jalr        = jr;
    bus.funct3      = f3;
    bus.zero        = z;
    bus.imm         = imm;
    bus.alu_result  = alu;
    bus.instr_ready = 1'b1;
    step();
    clear_inputs();
    n_checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr !== NOP || bus.imem_req !== 1'b1 ||
        bus.pc !== exp_next) begin
      n_fail++;
      $display("FAIL accept: valid=%b instr=%h req=%b pc=%h expected 0 %h 1 %h",
               bus.instr_valid, bus.instr, bus.imem_req, bus.pc, NOP, exp_next);
    end
  endtask

  task automatic run_instr(input int fd, input int ad, input logic [31:0] pc,
                           input logic br, input logic jp, input logic jr,
                           input logic [2:0] f3, input logic z,
                           input logic [31:0] imm, input logic [31:0] alu,
                           input logic [31:0] exp_next);
    logic [31:0] w;
    fetch_one(fd, pc, w);
    accept_one(ad, pc, w, br, jp, jr, f3, z, imm, alu, exp_next);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr !== NOP ||
          bus.pc !== 32'h0 || state_dbg !== S_RESET) begin
        n_fail++;
        $display("FAIL reset_hold: req=%b valid=%b instr=%h pc=%h state=%0d",
                 bus.imem_req, bus.instr_valid, bus.instr, bus.pc, state_dbg);
      end
    end
    exp_q.delete();
    exp_q.push_back(32'h0);
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.instr !== NOP ||
        bus.instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: req=%b addr=%h instr=%h valid=%b expected 1 0 %h 0",
               bus.imem_req, bus.imem_addr, bus.instr, bus.instr_valid, NOP);
    end
  endtask

  task automatic test_sequential();
    run_instr(0, 0, 32'h00, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h04);
    run_instr(0, 0, 32'h04, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h08);
    run_instr(0, 0, 32'h08, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0C);
    run_instr(0, 0, 32'h0C, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h10);
  endtask

  task automatic test_branch();
    run_instr(0, 0, 32'h10, 1, 0, 0, F3_BEQ, 1, 32'h20, 32'h0, 32'h30);
    run_instr(0, 0, 32'h30, 0, 1, 0, 3'b000, 0, 32'hFFFF_FFE0, 32'h0, 32'h10);
    run_instr(0, 0, 32'h10, 1, 0, 0, F3_BEQ, 0, 32'h20, 32'h0, 32'h14);
    run_instr(0, 0, 32'h14, 1, 0, 0, F3_BNE, 0, 32'h20, 32'h0, 32'h34);
    run_instr(0, 0, 32'h34, 1, 0, 0, F3_BNE, 1, 32'h20, 32'h0, 32'h38);
    run_instr(0, 0, 32'h38, 1, 0, 0, 3'b100, 1, 32'h20, 32'h0, 32'h3C);
  endtask

  task automatic test_jump();
    run_instr(0, 0, 32'h3C, 0, 0, 1, 3'b000, 0, 32'h0, 32'h40, 32'h40);
    run_instr(0, 0, 32'h40, 0, 1, 0, 3'b000, 0, 32'hFFFF_FFF0, 32'h0, 32'h30);
    run_instr(0, 0, 32'h30, 0, 0, 1, 3'b000, 0, 32'h0, 32'h105, 32'h104);
  endtask

  task automatic test_priority();
    run_instr(0, 0, 32'h104, 1, 1, 1, F3_BEQ, 1, 32'h8, 32'h200, 32'h200);
    run_instr(0, 0, 32'h200, 1, 1, 0, F3_BEQ, 0, 32'h10, 32'h0, 32'h210);
  endtask

  task automatic test_wrap();
    run_instr(0, 0, 32'h210, 0, 0, 1, 3'b000, 0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    run_instr(0, 0, 32'hFFFF_FFFC, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_stalls();
    run_instr(3, 4, 32'h00, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h04);
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] w;
    // Fetch of 0x4 is outstanding; stall it, then reset.
    step();
    step();
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL mid_req_setup: req=%b addr=%h expected 1 00000004",
               bus.imem_req, bus.imem_addr);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.pc !== 32'h0 || bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 ||
        bus.instr !== NOP || state_dbg !== S_RESET) begin
      n_fail++;
      $display("FAIL mid_req_reset: pc=%h req=%b valid=%b instr=%h state=%0d",
               bus.pc, bus.imem_req, bus.instr_valid, bus.instr, state_dbg);
    end
    exp_q.delete();
    exp_q.push_back(32'h0);
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_req_restart: req=%b addr=%h expected 1 00000000",
               bus.imem_req, bus.imem_addr);
    end
    run_instr(0, 0, 32'h00, 0, 0, 0, 3'b000, 0, 32'h0, 32'h0, 32'h04);
    fetch_one(0, 32'h4, w);
  endtask

`ifdef FETCH_MISALIGN_TRAP_EN
  task automatic test_misalign();
    logic [31:0] w;
    test_reset();
    n_checks++;
    if (misalign_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_reset: fault=%b expected 0", misalign_fault);
    end
    fetch_one(0, 32'h0, w);
    bus.jump        = 1'b1;
    bus.imm         = 32'h6;
    bus.instr_ready = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (misalign_fault !== 1'b1 || bus.pc !== 32'h6 || bus.imem_req !== 1'b0 ||
          bus.instr_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL misalign_halt: fault=%b pc=%h req=%b valid=%b expected 1 6 0 0",
                 misalign_fault, bus.pc, bus.imem_req, bus.instr_valid);
      end
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (misalign_fault !== 1'b0 || bus.pc !== 32'h0) begin
      n_fail++;
      $display("FAIL misalign_clear: fault=%b pc=%h expected 0 0", misalign_fault, bus.pc);
    end
    exp_q.delete();
    step();
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_priority();
    test_wrap();
    test_stalls();
    test_reset_mid_req();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d fetches outstanding, expected 0", exp_q.size());
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    test_misalign();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
